// File: rtl/cache_control_nway_if.sv
// CPU / physical-memory / datapath signal bundle for the N-way cache controller.
// The controller uses the slave modport; the surrounding system uses master.
interface cache_control_nway_if #(
  parameter int WAYS = 4
) ();
  localparam int WAYW = $clog2(WAYS);

  logic            mem_read;
  logic            mem_write;
  logic [3:0]      mem_byte_enable;
  logic            mem_resp;
  logic            pmem_read;
  logic            pmem_write;
  logic            pmem_resp;
  logic [WAYS-1:0] hit;
  logic [WAYS-1:0] valid;
  logic [WAYS-1:0] dirty;
  logic [WAYS-2:0] plru_out;
  logic [WAYS-1:0] load_data;
  logic [WAYS-1:0] load_tag;
  logic [WAYS-1:0] load_valid;
  logic [WAYS-1:0] load_dirty;
  logic            valid_in;
  logic            dirty_in;
  logic [WAYW-1:0] way_sel;
  logic            data_sel;
  logic            pmem_addr_sel;
  logic            load_plru;
  logic [WAYS-2:0] plru_in;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, pmem_resp, hit, valid, dirty, plru_out,
    output mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid, load_dirty,
           valid_in, dirty_in, way_sel, data_sel, pmem_addr_sel, load_plru, plru_in
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, pmem_resp, hit, valid, dirty, plru_out,
    input  mem_resp, pmem_read, pmem_write, load_data, load_tag, load_valid, load_dirty,
           valid_in, dirty_in, way_sel, data_sel, pmem_addr_sel, load_plru, plru_in
  );
endinterface

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back cache controller with tree pseudo-LRU.
// Optional saturating performance counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_control_nway #(
  parameter  int WAYS = 4,
  localparam int WAYW = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst_n,
  cache_control_nway_if.slave bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         perf_hits,
  output logic [31:0]         perf_misses,
  output logic [31:0]         perf_writebacks
`endif
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_e;

  state_e          state_q, state_d;
  logic [WAYW-1:0] victim_q, victim_d;
  logic [WAYW-1:0] hit_idx, victim_sel;
  logic [WAYS-1:0] hit_oh, victim_oh;
  logic            req, hit_any;
  // The byte mask is consumed by the datapath, not by this control block.
  logic            unused_be;

  assign unused_be = ^bus.mem_byte_enable;

  // PLRU node n lives in bit WAYS-2-n, so node 0 (the root) is the MSB.
  function automatic logic [WAYW-1:0] plru_victim(input logic [WAYS-2:0] t);
    int n;
    n = 0;
    for (int l = 0; l < WAYW; l++) n = 2 * n + 1 + int'(t[WAYS-2-n]);
    return WAYW'(n - (WAYS - 1));
  endfunction

  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] t,
                                                  input logic [WAYW-1:0] w);
    logic [WAYS-2:0] r;
    int n, p;
    r = t;
    n = int'(w) + WAYS - 1;
    for (int l = 0; l < WAYW; l++) begin
      p = (n - 1) / 2;
      r[WAYS-2-p] = ((n % 2) == 1);
      n = p;
    end
    return r;
  endfunction

  assign req       = bus.mem_read | bus.mem_write;
  assign hit_any   = |bus.hit;
  assign hit_oh    = WAYS'(1) << hit_idx;
  assign victim_oh = WAYS'(1) << victim_q;

  always_comb begin
    hit_idx    = '0;
    victim_sel = plru_victim(bus.plru_out);
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i])    hit_idx    = WAYW'(i);
      if (!bus.valid[i]) victim_sel = WAYW'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    bus.mem_resp      = 1'b0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;
    bus.load_data     = '0;
    bus.load_tag      = '0;
    bus.load_valid    = '0;
    bus.load_dirty    = '0;
    bus.valid_in      = 1'b0;
    bus.dirty_in      = 1'b0;
    bus.way_sel       = '0;
    bus.data_sel      = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.load_plru     = 1'b0;
    bus.plru_in       = '0;
    case (state_q)
      IDLE: if (req) state_d = COMPARE;
      COMPARE: begin
        if (!req) begin
          state_d = IDLE;
        end else if (hit_any) begin
          state_d       = IDLE;
          bus.mem_resp  = 1'b1;
          bus.way_sel   = hit_idx;
          bus.load_plru = 1'b1;
          bus.plru_in   = plru_update(bus.plru_out, hit_idx);
          if (bus.mem_write) begin
            bus.load_data  = hit_oh;
            bus.load_dirty = hit_oh;
            bus.dirty_in   = 1'b1;
          end
        end else begin
          victim_d = victim_sel;
          state_d  = (bus.valid[victim_sel] && bus.dirty[victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmem_addr_sel = 1'b1;
        bus.way_sel       = victim_q;
        if (bus.pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.load_data  = victim_oh;
          bus.load_tag   = victim_oh;
          bus.load_valid = victim_oh;
          bus.load_dirty = victim_oh;
          bus.valid_in   = 1'b1;
          bus.data_sel   = 1'b1;
          state_d        = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;
  // Set by a fill so the COMPARE that follows it is not mistaken for a cache hit.
  logic        fill_q, fill_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_comb begin
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    fill_d   = fill_q;
    if (state_q == COMPARE) begin
      fill_d = 1'b0;
      if (req && hit_any && !fill_q) hits_d   = sat_inc(hits_q);
      if (req && !hit_any)           misses_d = sat_inc(misses_q);
    end
    if (state_q == ALLOCATE && bus.pmem_resp)  fill_d = 1'b1;
    if (state_q == WRITEBACK && bus.pmem_resp) wbs_d  = sat_inc(wbs_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
      fill_q   <= 1'b0;
    end else begin
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
      fill_q   <= fill_d;
    end
  end

  assign perf_hits       = hits_q;
  assign perf_misses     = misses_q;
  assign perf_writebacks = wbs_q;
`endif

endmodule
